// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller's valid/ready port.
// Holds a grant for a whole transaction; a watchdog errors out accesses that never complete.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_valid,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic                    m0_ready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_err,
    input  logic                    m1_valid,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_ready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_err,
    output logic                    s_valid,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    grant,
    output logic                    busy
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic                   last;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;

    logic pick;
    logic timeout;
    logic done;

    // Tie goes to the master that did not win last time
    assign pick    = (m0_valid && m1_valid) ? ~last : m1_valid;
    assign timeout = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !s_ready
                     && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign done    = (state == BUSY) && (s_ready || timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant   <= pick;
                        last    <= pick;
                        cnt     <= '0;
                        addr_q  <= pick ? m1_addr  : m0_addr;
                        wdata_q <= pick ? m1_wdata : m0_wdata;
                        wstrb_q <= pick ? m1_wstrb : m0_wstrb;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state <= DRAIN;
                    end else if (cnt != {CNT_WIDTH{1'b1}}) begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Payload stays latched so the controller can finish the orphaned access
                    if (s_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign s_valid  = (state != IDLE) && !s_ready;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = s_valid ? wstrb_q : '0;

    assign m0_ready = done && !grant;
    assign m1_ready = done && grant;
    assign m0_err   = timeout && !grant;
    assign m1_err   = timeout && grant;
    assign m0_rdata = ((state == BUSY) && s_ready && !grant) ? s_rdata : '0;
    assign m1_rdata = ((state == BUSY) && s_ready && grant)  ? s_rdata : '0;

endmodule
